beam_threshold_loader: RTL

- Owns the shadow threshold store for a chain of NDUAL cascaded dual-beam trigger modules, two threshold sets per beam.
- On a commit request it serially shifts one set into the threshold cascade, then pulses that set's update strobe.
- Sits between the register/control interface and the first dual-beam module (its thresh_i / thresh_wr_i / thresh_update_i inputs).

---
 rtl/beam_thresh_pkg.sv | 25 ++
 rtl/beam_thresh_shadow.sv | 65 ++++++
 rtl/beam_threshold_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/beam_thresh_pkg.sv
// Shared types for the beam threshold loader: threshold words,
// loader FSM states and the no-trigger reset value.
package beam_thresh_pkg;

  localparam int NDUAL_DEF = 24;
  localparam int TBITS_DEF = 18;

  typedef logic [TBITS_DEF-1:0] thr_t;

  typedef struct packed {
    thr_t b;
    thr_t a;
  } dual_thr_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPD,
    DONE
  } state_e;

  // All-ones exceeds any 17-bit envelope, so nothing can trigger.
  localparam dual_thr_t THR_SAFE = '1;

endpackage

// File: rtl/beam_thresh_shadow.sv
// Two-set shadow threshold store: half-word write port and a
// registered full-word read port. Ports: write (we/set/entry/hi/dat), read (en/set/idx/dat).
module beam_thresh_shadow
  import beam_thresh_pkg::*;
#(
  parameter  int NDUAL = NDUAL_DEF,
  parameter  int TBITS = TBITS_DEF,
  localparam int EW    = $clog2(2*NDUAL) - 1,
  localparam int DW    = 2*TBITS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          wr_set_i,
  input  logic [EW-1:0] wr_entry_i,
  input  logic          wr_hi_i,
  input  logic [TBITS-1:0] wr_dat_i,
  input  logic          rd_en_i,
  input  logic          rd_set_i,
  input  logic [EW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_dat_o
);

  localparam logic [DW-1:0] RST_WORD = {DW{THR_SAFE[0]}};

  logic [DW-1:0] mem_q [2][NDUAL];
  logic [DW-1:0] mem_d [2][NDUAL];
  logic [DW-1:0] rd_dat_q;
  logic [DW-1:0] rd_dat_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      if (wr_hi_i) begin
        mem_d[wr_set_i][wr_entry_i][DW-1:TBITS] = wr_dat_i;
      end else begin
        mem_d[wr_set_i][wr_entry_i][TBITS-1:0] = wr_dat_i;
      end
    end
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en_i) begin
      rd_dat_d = mem_q[rd_set_i][rd_idx_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < 2; s++) begin
        for (int e = 0; e < NDUAL; e++) begin
          mem_q[s][e] <= RST_WORD;
        end
      end
      rd_dat_q <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/beam_threshold_loader.sv
// Shadow threshold store plus commit FSM that shifts one set into the
// dual-beam cascade and strobes its update. Ports: thr_* write, commit/busy/done, thresh_* cascade.
module beam_threshold_loader
  import beam_thresh_pkg::*;
#(
  parameter  int NDUAL = NDUAL_DEF,
  parameter  int TBITS = TBITS_DEF,
  localparam int AW    = $clog2(2*NDUAL)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AW-1:0]    thr_addr_i,
  input  logic             thr_set_i,
  input  logic [TBITS-1:0] thr_dat_i,
  input  logic             thr_valid_i,
  output logic             thr_ready_o,
  input  logic [1:0]       commit_i,
  output logic             busy_o,
  output logic [1:0]       done_o,
  output logic [2*TBITS-1:0] thresh_o,
  output logic [1:0]       thresh_wr_o,
  output logic [1:0]       thresh_update_o
);

  localparam int EW = AW - 1;
  localparam logic [EW-1:0] LAST_IDX = EW'(NDUAL - 1);
  localparam logic [AW:0]   NBEAM    = (AW+1)'(2*NDUAL);

  state_e        state_q, state_d;
  logic          cur_set_q, cur_set_d;
  logic [EW-1:0] idx_q, idx_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    upd_q, upd_d;
  logic [1:0]    done_q, done_d;

  logic busy;
  logic addr_ok;
  logic we;
  logic rd_en;

  assign busy = (state_q != IDLE);

  // Only the set being shifted is frozen; the other set stays writable.
  assign thr_ready_o = !(busy && (thr_set_i == cur_set_q));

  // Out-of-range beams are accepted but dropped.
  assign addr_ok = ({1'b0, thr_addr_i} < NBEAM);
  assign we      = thr_valid_i && thr_ready_o && addr_ok;

  beam_thresh_shadow #(
    .NDUAL (NDUAL),
    .TBITS (TBITS)
  ) u_shadow (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .we_i       (we),
    .wr_set_i   (thr_set_i),
    .wr_entry_i (thr_addr_i[AW-1:1]),
    .wr_hi_i    (thr_addr_i[0]),
    .wr_dat_i   (thr_dat_i),
    .rd_en_i    (rd_en),
    .rd_set_i   (cur_set_q),
    .rd_idx_i   (idx_q),
    .rd_dat_o   (thresh_o)
  );

  always_comb begin
    state_d   = state_q;
    cur_set_d = cur_set_q;
    idx_d     = idx_q;
    pend_d    = pend_q | commit_i;
    wr_d      = '0;
    upd_d     = '0;
    done_d    = '0;
    rd_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          // Set 0 wins; a commit in this same cycle re-arms.
          cur_set_d = !pend_q[0];
          pend_d    = (pend_q & (pend_q[0] ? 2'b10 : 2'b01))
                    | commit_i;
          idx_d     = LAST_IDX;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Farthest entry first so entry 0 lands at the head.
        rd_en           = 1'b1;
        wr_d[cur_set_q] = 1'b1;
        idx_d           = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = UPD;
        end
      end
      UPD: begin
        upd_d[cur_set_q] = 1'b1;
        state_d          = DONE;
      end
      DONE: begin
        done_d[cur_set_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cur_set_q <= 1'b0;
      idx_q     <= '0;
      pend_q    <= 2'b11;
      wr_q      <= '0;
      upd_q     <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_set_q <= cur_set_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      wr_q      <= wr_d;
      upd_q     <= upd_d;
      done_q    <= done_d;
    end
  end

  assign busy_o          = busy;
  assign thresh_wr_o     = wr_q;
  assign thresh_update_o = upd_q;
  assign done_o          = done_q;

endmodule
